// File: rtl/yin_cmnd_picker.sv
// YIN back-end: cumulative-mean-normalised difference via a restoring divider,
// then first-dip-below-threshold / global-minimum period selection per frame.
module yin_cmnd_picker #(
  parameter int WIDTH  = 32,
  parameter int TAUMAX = 2048,
  parameter int TAUMIN = 20,
  parameter int FRAC   = 10,
  parameter int QWIDTH = FRAC + 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [WIDTH-1:0]          diff_in,
  input  logic                      diff_valid_in,
  input  logic                      diff_last_in,
  output logic                      diff_ready_out,
  input  logic [QWIDTH-1:0]         threshold_in,
  output logic                      valid_out,
  output logic [$clog2(TAUMAX)-1:0] taumin,
  output logic [QWIDTH-1:0]         cmnd_out,
  output logic                      voiced_out
);
  localparam int TW = $clog2(TAUMAX);
  localparam int SW = WIDTH + TW;
  localparam int NW = SW + FRAC;
  localparam int DW = SW + QWIDTH;
  localparam int CW = $clog2(QWIDTH + 1);
  localparam logic [TW-1:0]     L_TMIN  = TW'(TAUMIN);
  localparam logic [TW-1:0]     L_TLAST = TW'(TAUMAX - 1);
  localparam logic [QWIDTH-1:0] QMAX    = '1;

  typedef enum logic [1:0] {IDLE, DIV, EVAL} state_t;

  state_t              r_state, w_state_nxt;
  logic [TW-1:0]       r_tau, r_cur_tau_p0, r_dip_tau, r_g_tau;
  logic [SW-1:0]       r_sum;
  logic [QWIDTH-1:0]   r_thr, r_q_p0, r_prev, r_dip_val, r_g_val;
  logic [DW-1:0]       r_rem_p0, r_dvs_p0;
  logic [CW-1:0]       r_cnt;
  logic                r_sat_p0, r_last_p0, r_locked, r_dipping, r_have;

  logic                w_acc, w_search, w_fend_in, w_fend_now;
  logic [SW-1:0]       w_sum_nxt, w_prod;
  logic [NW-1:0]       w_num;
  logic [DW-1:0]       w_num_ext, w_dvs_full;
  logic [QWIDTH-1:0]   w_dq, w_dval, w_gval, w_out_val;
  logic [TW-1:0]       w_dtau, w_gtau, w_out_tau;
  logic                w_lk, w_dp, w_have, w_out_voiced;

  function automatic logic [QWIDTH-1:0] f_sat(input logic sat, input logic [QWIDTH-1:0] q);
    return sat ? QMAX : q;
  endfunction

  assign w_acc      = diff_valid_in & diff_ready_out;
  assign w_search   = (r_tau >= L_TMIN) & ~r_locked;
  assign w_fend_in  = diff_last_in | (r_tau == L_TLAST);
  // d(0) is excluded from the running sum
  assign w_sum_nxt  = (r_tau == '0) ? '0 : r_sum + SW'(diff_in);
  assign w_prod     = SW'(diff_in) * SW'(r_tau);
  assign w_num      = {w_prod, {FRAC{1'b0}}};
  assign w_num_ext  = {{(QWIDTH-FRAC){1'b0}}, w_num};
  assign w_dvs_full = {w_sum_nxt, {QWIDTH{1'b0}}};
  assign w_fend_now = (w_acc & ~w_search & w_fend_in) | ((r_state == EVAL) & r_last_p0);

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    diff_ready_out = 1'b0;
    case (r_state)
      IDLE: begin
        diff_ready_out = ~rst_in;
        if (diff_valid_in && w_search && !rst_in) w_state_nxt = DIV;
      end
      DIV:     if (r_cnt == CW'(QWIDTH - 1)) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Search update: only EVAL changes the records; elsewhere they pass through
  always_comb begin
    w_dq   = f_sat(r_sat_p0, r_q_p0);
    w_lk   = r_locked;
    w_dp   = r_dipping;
    w_have = r_have;
    w_dtau = r_dip_tau;
    w_dval = r_dip_val;
    w_gtau = r_g_tau;
    w_gval = r_g_val;
    if (r_state == EVAL) begin
      w_have = 1'b1;
      if (!r_have || w_dq < r_g_val) begin
        w_gtau = r_cur_tau_p0;
        w_gval = w_dq;
      end
      if (!r_dipping) begin
        if (w_dq < r_thr) begin
          w_dp   = 1'b1;
          w_dtau = r_cur_tau_p0;
          w_dval = w_dq;
        end
      end else if (w_dq >= r_prev) begin
        w_lk = 1'b1;
      end else if (w_dq < r_dip_val) begin
        w_dtau = r_cur_tau_p0;
        w_dval = w_dq;
      end
    end
    if (w_lk || w_dp) begin
      w_out_tau = w_dtau;  w_out_val = w_dval;  w_out_voiced = 1'b1;
    end else if (w_have) begin
      w_out_tau = w_gtau;  w_out_val = w_gval;  w_out_voiced = 1'b0;
    end else begin
      w_out_tau = '0;      w_out_val = QMAX;    w_out_voiced = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tau      <= '0;
      r_sum      <= '0;
      r_locked   <= 1'b0;
      r_dipping  <= 1'b0;
      r_have     <= 1'b0;
      valid_out  <= 1'b0;
      taumin     <= '0;
      cmnd_out   <= '0;
      voiced_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      r_locked  <= w_lk;
      r_dipping <= w_dp;
      r_have    <= w_have;
      if (w_acc) begin
        r_tau <= w_fend_in ? '0 : r_tau + 1'b1;
        r_sum <= w_sum_nxt;
      end
      if (w_fend_now) begin
        valid_out  <= 1'b1;
        taumin     <= w_out_tau;
        cmnd_out   <= w_out_val;
        voiced_out <= w_out_voiced;
        r_locked   <= 1'b0;
        r_dipping  <= 1'b0;
        r_have     <= 1'b0;
      end
    end
  end

  // p0: divider operands captured on a search-beat accept, one quotient bit per DIV cycle
  always_ff @(posedge clk_in) begin
    r_dip_tau <= w_dtau;
    r_dip_val <= w_dval;
    r_g_tau   <= w_gtau;
    r_g_val   <= w_gval;
    if (r_state == EVAL) r_prev <= w_dq;
    if (w_acc && r_tau == '0) r_thr <= threshold_in;
    if (w_acc && w_search) begin
      r_cur_tau_p0 <= r_tau;
      r_last_p0    <= w_fend_in;
      r_rem_p0     <= w_num_ext;
      r_dvs_p0     <= w_dvs_full >> 1;
      r_q_p0       <= '0;
      r_cnt        <= '0;
      r_sat_p0     <= (w_sum_nxt == '0) | (w_num_ext >= w_dvs_full);
    end
    if (r_state == DIV) begin
      if (r_rem_p0 >= r_dvs_p0) begin
        r_rem_p0 <= r_rem_p0 - r_dvs_p0;
        r_q_p0   <= {r_q_p0[QWIDTH-2:0], 1'b1};
      end else begin
        r_q_p0   <= {r_q_p0[QWIDTH-2:0], 1'b0};
      end
      r_dvs_p0 <= r_dvs_p0 >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_yin_cmnd_picker.sv
// Directed bench for yin_cmnd_picker with TAUMAX=64, TAUMIN=4, FRAC=10.
module tb_yin_cmnd_picker;
  localparam int WIDTH = 32, TAUMAX = 64, TAUMIN = 4, FRAC = 10, QWIDTH = 14;

  logic              clk = 1'b0;
  logic              rst_in;
  logic [WIDTH-1:0]  diff_in;
  logic              diff_valid_in, diff_last_in, diff_ready_out;
  logic [QWIDTH-1:0] threshold_in;
  logic              valid_out, voiced_out;
  logic [5:0]        taumin;
  logic [QWIDTH-1:0] cmnd_out;

  yin_cmnd_picker #(.WIDTH(WIDTH), .TAUMAX(TAUMAX), .TAUMIN(TAUMIN), .FRAC(FRAC), .QWIDTH(QWIDTH)) dut (
    .clk_in(clk), .rst_in(rst_in), .diff_in(diff_in), .diff_valid_in(diff_valid_in),
    .diff_last_in(diff_last_in), .diff_ready_out(diff_ready_out), .threshold_in(threshold_in),
    .valid_out(valid_out), .taumin(taumin), .cmnd_out(cmnd_out), .voiced_out(voiced_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int n_valid = 0, v_cyc = 0;
  logic [5:0]        v_tau;
  logic [QWIDTH-1:0] v_cmnd;
  logic              v_voiced;
  int acc_c [64];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_out) begin
      n_valid++;
      v_cyc    = cyc;
      v_tau    = taumin;
      v_cmnd   = cmnd_out;
      v_voiced = voiced_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_d(input int pat, input int tau);
    if (pat == 0) return 32'd1000;
    if (pat == 2) return 32'd0;
    if (tau == 20 || tau == 22) return 32'd10;
    if (tau == 21) return 32'd2;
    return 32'd100;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic beat(input logic [31:0] d, input logic last, output int ac);
    int n;
    n  = 0;
    ac = -1;
    diff_in = d;  diff_last_in = last;  diff_valid_in = 1'b1;
    while (ac < 0 && n < 200) begin
      @(negedge clk);
      if (diff_ready_out) ac = cyc;
      n++;
    end
    if (ac < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: beat not accepted within %0d cycles", n);
    end
    @(posedge clk);
    #1;
    diff_valid_in = 1'b0;
    diff_last_in  = 1'b0;
  endtask

  task automatic frame(input int pat, input int last_at, input logic [QWIDTH-1:0] thr,
                       input int chg_at, input logic [QWIDTH-1:0] chg_thr, input int rst_at);
    threshold_in = thr;
    for (int t = 0; t < 64; t++) begin
      if (t == chg_at) threshold_in = chg_thr;
      if (t == rst_at) begin
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        break;
      end
      beat(f_d(pat, t), (t == last_at) || (t == 63), acc_c[t]);
      if (t == last_at) break;
    end
  endtask

  task automatic expect_result(input string tag, input int nb, input int etau, input int ecmnd, input int evoiced);
    int n;
    n = 0;
    while (n_valid == nb && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_pulses"}, n_valid - nb, 1);
    chk({tag, "_taumin"}, 32'(v_tau), etau);
    chk({tag, "_cmnd"}, 32'(v_cmnd), ecmnd);
    chk({tag, "_voiced"}, 32'(v_voiced), evoiced);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    rst_in = 1'b1;  diff_in = '0;  diff_valid_in = 1'b0;  diff_last_in = 1'b0;
    threshold_in = 14'd102;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_taumin", 32'(taumin), 0);
    chk("rst_cmnd", 32'(cmnd_out), 0);
    chk("rst_voiced", 32'(voiced_out), 0);
    chk("rst_ready", 32'(diff_ready_out), 0);
    @(posedge clk);
    #1;
    rst_in = 1'b0;

    nb = n_valid;
    frame(0, -1, 14'd102, -1, 14'd0, -1);
    expect_result("const", nb, 4, 1024, 0);

    nb = n_valid;
    frame(1, -1, 14'd102, -1, 14'd0, -1);
    expect_result("dip", nb, 21, 22, 1);
    chk("fast_rate", acc_c[4] - acc_c[0], 4);
    chk("search_gap4", acc_c[5] - acc_c[4], 16);
    chk("search_gap21", acc_c[22] - acc_c[21], 16);
    chk("lock_gap", acc_c[23] - acc_c[22], 16);
    chk("post_lock_rate", acc_c[63] - acc_c[23], 40);
    chk("valid_lat_fast", v_cyc - acc_c[63], 1);

    nb = n_valid;
    frame(2, -1, 14'd102, -1, 14'd0, -1);
    expect_result("zero", nb, 4, 16383, 0);

    nb = n_valid;
    frame(1, 21, 14'd102, -1, 14'd0, -1);
    expect_result("early_last", nb, 21, 22, 1);
    chk("valid_lat_search", v_cyc - acc_c[21], 16);

    nb = n_valid;
    frame(1, -1, 14'd102, 2, 14'd2000, -1);
    expect_result("thr_change", nb, 21, 22, 1);

    nb = n_valid;
    frame(0, 2, 14'd102, -1, 14'd0, -1);
    expect_result("empty", nb, 0, 16383, 0);
    chk("valid_lat_empty", v_cyc - acc_c[2], 1);

    nb = n_valid;
    frame(1, -1, 14'd102, 30, 14'd0, 30);
    repeat (20) @(negedge clk);
    chk("abort_no_valid", n_valid - nb, 0);
    @(posedge clk);
    #1;
    nb = n_valid;
    frame(1, -1, 14'd0, -1, 14'd0, -1);
    expect_result("after_rst", nb, 21, 22, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
